// File: rtl/tsb_pkg.sv
// Shared types and sizing helpers for the tristate bus arbiter.
package tsb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } tsb_state_e;

  // Bits needed to index n values; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tristate_bus_arb_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping modulo N_CH.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int PW   = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            valid
);

  logic [2*N_CH-1:0] w_dbl;
  logic [N_CH-1:0]   w_rot;
  logic [PW:0]       w_sum;

  always_comb begin
    w_dbl  = {req, req} >> ptr;
    w_rot  = w_dbl[N_CH-1:0];
    w_sum  = '0;
    winner = '0;
    valid  = |req;
    // Scan from the far end so the smallest offset from ptr wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum  = {1'b0, ptr} + (PW+1)'(k);
        winner = (w_sum >= (PW+1)'(N_CH)) ? PW'(w_sum - (PW+1)'(N_CH)) : w_sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arb.sv
// Round-robin tristate bus arbiter with one-cycle turnaround between owners.
// Optional bus keeper enabled by defining TSB_BUS_KEEPER_EN.
module tristate_bus_arb
  import tsb_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH*W-1:0] din,
  output tri   [W-1:0]      bus_y,
  output logic [N_CH-1:0]   gnt,
  output logic              busy
);

  localparam int PW = cnt_width(N_CH);
  localparam int TW = cnt_width(HOLD_MAX + 1);

  tsb_state_e      r_state, w_state_next;
  logic [PW-1:0]   r_winner, w_winner_next;
  logic [PW-1:0]   r_ptr, w_ptr_next, w_ptr_inc;
  logic [PW-1:0]   w_pick_idx, w_pick_ptr;
  logic [TW-1:0]   r_tenure, w_tenure_next;
  logic [N_CH-1:0] r_gnt, w_gnt_next;
  logic [N_CH-1:0] w_owner_mask, w_pick_req;
  logic            r_busy, w_pick_valid, w_release;
  logic [W-1:0]    w_din_arr [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_din
      assign w_din_arr[gi] = din[gi*W +: W];
    end
  endgenerate

  always_comb begin
    w_owner_mask           = '0;
    w_owner_mask[r_winner] = 1'b1;
    w_ptr_inc  = (r_winner == PW'(N_CH - 1)) ? '0 : r_winner + PW'(1);
    w_release  = (r_state == OWN) &&
                 (!req[r_winner] ||
                  ((r_tenure == TW'(HOLD_MAX)) && (|(req & ~w_owner_mask))));
    // While owning, the next winner is chosen from the other channels only.
    w_pick_req = (r_state == OWN) ? (req & ~w_owner_mask) : req;
    w_pick_ptr = (r_state == OWN) ? w_ptr_inc : r_ptr;
  end

  rr_pick #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_rr_pick (
    .req    (w_pick_req),
    .ptr    (w_pick_ptr),
    .winner (w_pick_idx),
    .valid  (w_pick_valid)
  );

  always_comb begin
    w_state_next  = r_state;
    w_winner_next = r_winner;
    w_ptr_next    = r_ptr;
    w_tenure_next = r_tenure;
    w_gnt_next    = r_gnt;
    case (r_state)
      IDLE: begin
        w_gnt_next = '0;
        if (w_pick_valid) begin
          w_winner_next = w_pick_idx;
          w_state_next  = TURN;
        end
      end
      TURN: begin
        if (req[r_winner]) begin
          w_state_next  = OWN;
          w_gnt_next    = w_owner_mask;
          w_tenure_next = TW'(1);
        end else begin
          w_state_next = IDLE;
          w_gnt_next   = '0;
        end
      end
      OWN: begin
        if (w_release) begin
          w_ptr_next = w_ptr_inc;
          w_gnt_next = '0;
          if (w_pick_valid) begin
            w_winner_next = w_pick_idx;
            w_state_next  = TURN;
          end else begin
            w_state_next = IDLE;
          end
        end else if (r_tenure != TW'(HOLD_MAX)) begin
          w_tenure_next = r_tenure + TW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_winner <= '0;
      r_ptr    <= '0;
      r_tenure <= '0;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_winner <= w_winner_next;
      r_ptr    <= w_ptr_next;
      r_tenure <= w_tenure_next;
      r_gnt    <= w_gnt_next;
      r_busy   <= (w_state_next != IDLE);
    end
  end

  assign gnt  = r_gnt;
  assign busy = r_busy;

`ifdef TSB_BUS_KEEPER_EN
  logic [W-1:0] r_keep;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_keep <= '0;
    end else if (r_state == OWN) begin
      r_keep <= w_din_arr[r_winner];
    end
  end

  assign bus_y = (|r_gnt) ? w_din_arr[r_winner] : r_keep;
`else
  assign bus_y = (|r_gnt) ? w_din_arr[r_winner] : {W{1'bz}};
`endif

endmodule

// File: tb/tb_tristate_bus_arb.sv
// Directed bench for tristate_bus_arb (N_CH=4, W=4, HOLD_MAX=8); bus is pulled up so Z reads as all ones.
module tb_tristate_bus_arb;

  localparam int N_CH = 4;
  localparam int W    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] req;
  logic [N_CH*W-1:0] din;
  tri1  [W-1:0]    bus_y;
  logic [N_CH-1:0] gnt;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] keep_exp;

  tristate_bus_arb #(
    .N_CH     (N_CH),
    .W        (W),
    .HOLD_MAX (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .din   (din),
    .bus_y (bus_y),
    .gnt   (gnt),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    $display("vec %0d %s obs=%0h exp=%0h", n_vec, tag, obs, exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value the bus should show with no owner: pulled-up Z, or the keeper value.
  function automatic logic [W-1:0] idle_bus(input logic [W-1:0] k);
`ifdef TSB_BUS_KEEPER_EN
    return k;
`else
    return {W{1'b1}};
`endif
  endfunction

  task automatic chk_idle(input string tag, input logic exp_busy);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "_bus"}, 32'(bus_y), 32'(idle_bus(keep_exp)));
  endtask

  task automatic chk_own(input string tag, input int ch);
    logic [N_CH-1:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
    chk({tag, "_busy"}, 32'(busy), 32'h1);
    chk({tag, "_bus"}, 32'(bus_y), 32'(ch + 1));
  endtask

  initial begin
    int owners [5];
    owners = '{0, 1, 2, 3, 0};
    // Channel i drives value i+1 so every owner is distinguishable from Z.
    din = {4'h4, 4'h3, 4'h2, 4'h1};
    rst = 1'b1;
    req = '0;
    keep_exp = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset", 1'b0);

    // Single request: TURN then grant two edges after req.
    req = 4'b0001;
    tick();
    chk_idle("single_turn", 1'b1);
    tick();
    chk_own("single_own", 0);
    tick();
    chk_own("single_own2", 0);
    req = 4'b0000;
    tick();
    keep_exp = 4'h1;
    chk_idle("single_release", 1'b0);

    // Full contention from a fresh reset: 0,1,2,3,0 each for 8 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    keep_exp = '0;
    req = 4'b1111;
    tick();
    chk_idle("rr_first_turn", 1'b1);
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        chk_own($sformatf("rr_own%0d_c%0d", owners[i], c + 1), owners[i]);
      end
      tick();
      keep_exp = W'(owners[i] + 1);
      chk_idle($sformatf("rr_turn_after%0d", owners[i]), 1'b1);
    end
    // TURN for channel 1; dropping all requests returns to IDLE.
    req = 4'b0000;
    tick();
    chk_idle("rr_drop_idle", 1'b0);

    // Owner 2 drops while channel 1 asserts: straight to TURN, then owner 1.
    req = 4'b0100;
    tick();
    chk_idle("swap_turn2", 1'b1);
    tick();
    chk_own("swap_own2", 2);
    tick();
    chk_own("swap_own2b", 2);
    req = 4'b0010;
    tick();
    keep_exp = 4'h3;
    chk_idle("swap_turn1", 1'b1);
    tick();
    chk_own("swap_own1", 1);

    // Reset while channel 2 owns; next grant restarts from channel 0.
    req = 4'b0100;
    tick();
    keep_exp = 4'h2;
    chk_idle("rst_turn2", 1'b1);
    tick();
    chk_own("rst_own2", 2);
    rst = 1'b1;
    req = 4'b1111;
    tick();
    keep_exp = '0;
    chk_idle("rst_applied", 1'b0);
    rst = 1'b0;
    tick();
    chk_idle("rst_turn0", 1'b1);
    tick();
    chk_own("rst_own0", 0);

    // Winner drops during TURN: back to IDLE with no grant.
    req = 4'b0000;
    tick();
    keep_exp = 4'h1;
    chk_idle("drop_idle", 1'b0);
    req = 4'b1000;
    tick();
    chk_idle("drop_turn3", 1'b1);
    req = 4'b0000;
    tick();
    chk_idle("drop_in_turn", 1'b0);
    tick();
    chk_idle("drop_stay_idle", 1'b0);

    // Sole requester keeps the bus past HOLD_MAX; contention then forces release.
    req = 4'b0100;
    tick();
    chk_idle("sole_turn", 1'b1);
    for (int c = 0; c < 12; c++) begin
      tick();
      chk_own($sformatf("sole_own_c%0d", c + 1), 2);
    end
    req = 4'b0110;
    tick();
    keep_exp = 4'h3;
    chk_idle("sole_contend_turn", 1'b1);
    tick();
    chk_own("sole_next_own1", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
